tmds_gearbox: RTL and testbench

- Parametrised, IP-less, single-clock parallel-to-serial gearbox for the HDMI output path. Runs entirely on clk_pixel_x5.
- Accepts one WORD_W-bit symbol per channel through a valid/ready handshake and emits OUT_W bits per channel per cycle, for a DDR or SDR output primitive.
- Also emits a synchronous forwarded-clock pattern, applies per-lane polarity inversion for board swaps, and fills underflows with a control symbol instead of corrupting the link.

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_gearbox_lane.sv | 67 ++++++
 rtl/tmds_gearbox.sv | 175 +++++++++++++++++
 tb/tb_tmds_gearbox.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS symbol constants and helpers shared by the serial gearbox
// Contents: control symbols, forwarded-clock pattern, 10-bit word type, bit reversal.
package tmds_pkg;

    typedef logic [9:0] tmds_word_t;

    // DVI/HDMI control-period symbols, indexed by {C1, C0}.
    localparam tmds_word_t TMDS_CTRL_00 = 10'b1101010100;
    localparam tmds_word_t TMDS_CTRL_01 = 10'b0010101011;
    localparam tmds_word_t TMDS_CTRL_10 = 10'b0101010100;
    localparam tmds_word_t TMDS_CTRL_11 = 10'b1010101011;

    // Five ones then five zeros: one pixel-clock period on the forwarded-clock lane.
    localparam tmds_word_t TMDS_CLK_PATTERN = 10'b0000011111;

    function automatic tmds_word_t bit_reverse(input tmds_word_t w);
        tmds_word_t r;
        for (int b = 0; b < 10; b++) begin
            r[b] = w[9-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_gearbox_lane.sv
// rtl/tmds_gearbox_lane.sv - one serial lane: shift register, optional reversal, polarity, output register
// Ports:
//   clk       - serial clock
//   reset     - synchronous active-high reset
//   idle      - gearbox disabled: reload RESET_WORD, drive the rest value
//   load      - load load_data into the shift register this cycle
//   out_en    - output register follows the shift register (else rest value)
//   load_data - word to load
//   out_bits  - registered OUT_W-bit slice, bit 0 sent first
module tmds_gearbox_lane #(
    parameter int              WORD_W     = 10,
    parameter int              OUT_W      = 2,
    parameter bit              REVERSE    = 1'b0,
    parameter bit              INVERT     = 1'b0,
    parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idle,
    input  logic              load,
    input  logic              out_en,
    input  logic [WORD_W-1:0] load_data,
    output logic [OUT_W-1:0]  out_bits
);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;
    logic [WORD_W-1:0] load_word;
    logic [OUT_W-1:0]  out_q;
    logic [OUT_W-1:0]  out_d;

    always_comb begin
        load_word = load_data;
        // MSB-first links are served by reversing once on load, so the
        // shifter always sends its bit 0 first.
        if (REVERSE) begin
            for (int b = 0; b < WORD_W; b++) begin
                load_word[b] = load_data[WORD_W-1-b];
            end
        end

        sr_d = sr_q >> OUT_W;
        if (idle) begin
            sr_d = RESET_WORD;
        end else if (load) begin
            sr_d = load_word;
        end

        out_d = {OUT_W{INVERT}};
        if (out_en) begin
            out_d = sr_q[OUT_W-1:0] ^ {OUT_W{INVERT}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= RESET_WORD;
            out_q <= {OUT_W{INVERT}};
        end else begin
            sr_q  <= sr_d;
            out_q <= out_d;
        end
    end

    assign out_bits = out_q;

endmodule

// File: rtl/tmds_gearbox.sv
// rtl/tmds_gearbox.sv - single-clock TMDS parallel-to-serial gearbox with forwarded clock
// Ports:
//   clk_pixel_x5     - serial clock, the only clock
//   reset            - synchronous active-high reset
//   enable           - run the gearbox
//   in_valid/ready   - symbol-set handshake
//   in_data          - one symbol per lane
//   out_bits         - per-lane serial slices, bit 0 sent first
//   out_clock        - forwarded-clock slice
//   word_start       - out_bits carries slice 0 of a word
//   underflow_clear  - clears underflow_sticky
//   underflow_sticky - an idle symbol was substituted since the last clear/reset
module tmds_gearbox
    import tmds_pkg::*;
#(
    parameter int                      NUM_CHANNELS = 3,
    parameter int                      WORD_W       = 10,
    parameter int                      OUT_W        = 2,
    parameter bit                      LSB_FIRST    = 1'b1,
    parameter logic [WORD_W-1:0]       IDLE_WORD    = TMDS_CTRL_00,
    parameter logic [WORD_W-1:0]       CLK_PATTERN  = TMDS_CLK_PATTERN,
    parameter logic [NUM_CHANNELS-1:0] INVERT_MASK  = '0,
    parameter bit                      INVERT_CLOCK = 1'b0
) (
    input  logic              clk_pixel_x5,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data [NUM_CHANNELS],
    output logic [OUT_W-1:0]  out_bits [NUM_CHANNELS],
    output logic [OUT_W-1:0]  out_clock,
    output logic              word_start,
    input  logic              underflow_clear,
    output logic              underflow_sticky
);

    localparam int RATIO = WORD_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] hold_q [NUM_CHANNELS];
    logic [WORD_W-1:0] hold_d [NUM_CHANNELS];
    logic              sticky_q, sticky_d;
    logic              word_start_q, word_start_d;

    logic              load;
    logic              accept;
    logic              lane_load;
    logic              underflow;
    logic              run_out;
    logic [WORD_W-1:0] load_src [NUM_CHANNELS];

    // The first enabled cycle out of IDLE is a load because cnt parks at CNT_LAST.
    assign load     = ((state_q == ST_RUN) || enable) && (cnt_q == CNT_LAST);
    assign in_ready = enable && !reset && (!hold_valid_q || load);
    assign accept   = in_valid && in_ready;
    assign run_out  = (state_q == ST_RUN) && enable;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        lane_load    = 1'b0;
        underflow    = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            load_src[i] = IDLE_WORD;
        end

        if (!enable) begin
            // Any half-sent word is abandoned silently.
            state_d      = ST_IDLE;
            cnt_d        = CNT_LAST;
            hold_valid_d = 1'b0;
        end else begin
            state_d = ST_RUN;
            if (load) begin
                cnt_d     = '0;
                lane_load = 1'b1;
                if (hold_valid_q) begin
                    // Hold is older than anything arriving now; a concurrent
                    // accept takes its place.
                    load_src     = hold_q;
                    hold_valid_d = accept;
                    if (accept) begin
                        hold_d = in_data;
                    end
                end else if (accept) begin
                    load_src = in_data;
                end else begin
                    underflow = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (accept) begin
                    hold_valid_d = 1'b1;
                    hold_d       = in_data;
                end
            end
        end

        // A new underflow wins over a clear in the same cycle.
        sticky_d = sticky_q;
        if (underflow) begin
            sticky_d = 1'b1;
        end else if (underflow_clear) begin
            sticky_d = 1'b0;
        end

        word_start_d = run_out && (cnt_q == '0);
    end

    always_ff @(posedge clk_pixel_x5) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_LAST;
            hold_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_valid_q <= hold_valid_d;
            sticky_q     <= sticky_d;
            word_start_q <= word_start_d;
        end
        hold_q <= hold_d;
    end

    assign word_start       = word_start_q;
    assign underflow_sticky = sticky_q;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        tmds_gearbox_lane #(
            .WORD_W     (WORD_W),
            .OUT_W      (OUT_W),
            .REVERSE    (!LSB_FIRST),
            .INVERT     (INVERT_MASK[i]),
            .RESET_WORD (IDLE_WORD)
        ) u_lane (
            .clk       (clk_pixel_x5),
            .reset     (reset),
            .idle      (!enable),
            .load      (lane_load),
            .out_en    (run_out),
            .load_data (load_src[i]),
            .out_bits  (out_bits[i])
        );
    end

    // The clock lane is never reversed: its pattern is defined in send order.
    tmds_gearbox_lane #(
        .WORD_W     (WORD_W),
        .OUT_W      (OUT_W),
        .REVERSE    (1'b0),
        .INVERT     (INVERT_CLOCK),
        .RESET_WORD (CLK_PATTERN)
    ) u_clk_lane (
        .clk       (clk_pixel_x5),
        .reset     (reset),
        .idle      (!enable),
        .load      (lane_load),
        .out_en    (run_out),
        .load_data (CLK_PATTERN),
        .out_bits  (out_clock)
    );

endmodule

// File: tb/tb_tmds_gearbox.sv
// tb/tb_tmds_gearbox.sv - self-checking bench for tmds_gearbox (three parameter sets)
module tb_tmds_gearbox;

    localparam logic [9:0] IDLE_W = 10'b1101010100;
    localparam logic [9:0] CLKP   = 10'b0000011111;
    localparam int         HN     = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] in_data [3];

    logic       rdy_a, rdy_b, rdy_c;
    logic [1:0] ob_a [3];
    logic [1:0] ob_b [3];
    logic [1:0] ob_c [3];
    logic [1:0] ck_a, ck_b, ck_c;
    logic       ws_a, ws_b, ws_c, uf_a, uf_b, uf_c;

    logic [1:0] obx [3][3];
    logic [1:0] ckx [3];
    logic       wsx [3];
    logic       ufx [3];
    logic       rdx [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int feed_idx = 0;
    int feed_lim = 0;
    int n_acc   = 0;
    int e_cyc   = 0;
    int b_cyc   = 100000;
    int x_cyc   = 0;

    logic [9:0] w_tab [64][3];

    // model state
    logic [29:0] mq [$];
    bit          m_run = 1'b0;
    bit          m_sticky = 1'b0;
    int          next_load = 0;
    bit          exp_has [HN + 8];
    int          exp_k   [HN + 8];
    logic [9:0]  exp_w   [HN + 8][3];

    // history for hand-computed pins
    logic [1:0] h_a0 [HN];
    logic [1:0] h_b1 [HN];
    logic [1:0] h_c0 [HN];
    logic [1:0] h_c1 [HN];
    logic [1:0] h_cka [HN];
    logic [1:0] h_ckc [HN];
    logic       h_ws [HN];
    logic       h_uf [HN];
    logic       h_rdy [HN];

    logic [1:0] pin_a0  [10] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    logic [1:0] pin_b1  [5]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] pin_cka [5]  = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [1:0] pin_ckc [5]  = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};
    logic [1:0] pin_c0  [5]  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [1:0] pin_c1  [5]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};

    always #5 clk = ~clk;

    tmds_gearbox dut_a (
        .clk_pixel_x5(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_bits(ob_a), .out_clock(ck_a), .word_start(ws_a),
        .underflow_clear(clr), .underflow_sticky(uf_a)
    );

    tmds_gearbox #(.LSB_FIRST(1'b0)) dut_b (
        .clk_pixel_x5(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_bits(ob_b), .out_clock(ck_b), .word_start(ws_b),
        .underflow_clear(clr), .underflow_sticky(uf_b)
    );

    tmds_gearbox #(.INVERT_MASK(3'b001), .INVERT_CLOCK(1'b1)) dut_c (
        .clk_pixel_x5(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
        .out_bits(ob_c), .out_clock(ck_c), .word_start(ws_c),
        .underflow_clear(clr), .underflow_sticky(uf_c)
    );

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obx[0][i] = ob_a[i];
            obx[1][i] = ob_b[i];
            obx[2][i] = ob_c[i];
        end
        ckx[0] = ck_a; ckx[1] = ck_b; ckx[2] = ck_c;
        wsx[0] = ws_a; wsx[1] = ws_b; wsx[2] = ws_c;
        ufx[0] = uf_a; ufx[1] = uf_b; ufx[2] = uf_c;
        rdx[0] = rdy_a; rdx[1] = rdy_b; rdx[2] = rdy_c;
    end

    // Slice k of a word in send order: first sent bit lands in slice bit 0.
    function automatic logic [1:0] slice_of(input logic [9:0] w, input int k, input bit lsb);
        logic [9:0] v;
        v = w;
        if (!lsb) begin
            for (int b = 0; b < 10; b++) v[b] = w[9-b];
        end
        return 2'((v >> (2 * k)) & 10'h003);
    endfunction

    task automatic chk(input string nm, input int d, input int ln,
                       input logic [9:0] act, input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d lane=%0d cyc=%0d actual=%0h required=%0h",
                     nm, d, ln, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [1:0]  e;
        logic [29:0] wset;
        bit          ld, r_exp, has, uf, acc;
        has = exp_has[cyc];
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) begin
                e = has ? slice_of(exp_w[cyc][i], exp_k[cyc], d != 1) : 2'b00;
                if (d == 2 && i == 0) e = e ^ 2'b11;
                chk("out_bits", d, i, 10'(obx[d][i]), 10'(e));
            end
            e = has ? slice_of(CLKP, exp_k[cyc], 1'b1) : 2'b00;
            if (d == 2) e = e ^ 2'b11;
            chk("out_clock", d, -1, 10'(ckx[d]), 10'(e));
            chk("word_start", d, -1, 10'(wsx[d]), 10'(has && exp_k[cyc] == 0));
            chk("underflow_sticky", d, -1, 10'(ufx[d]), 10'(m_sticky));
        end
        ld    = !reset && enable && (!m_run || cyc == next_load);
        r_exp = !reset && enable && (mq.size() == 0 || ld);
        for (int d = 0; d < 3; d++) chk("in_ready", d, -1, 10'(rdx[d]), 10'(r_exp));

        if (cyc < HN) begin
            h_a0[cyc] = ob_a[0];  h_b1[cyc] = ob_b[1];
            h_c0[cyc] = ob_c[0];  h_c1[cyc] = ob_c[1];
            h_cka[cyc] = ck_a;    h_ckc[cyc] = ck_c;
            h_ws[cyc] = ws_a;     h_uf[cyc] = uf_a;  h_rdy[cyc] = rdy_a;
        end

        acc = in_valid && rdy_a;
        if (acc) feed_idx++;
        if (acc && cyc >= b_cyc + 5 && cyc <= b_cyc + 104) n_acc++;

        if (reset || !enable) begin
            mq.delete();
            m_run = 1'b0;
            for (int j = 1; j <= 7; j++) exp_has[cyc + j] = 1'b0;
            if (reset || clr) m_sticky = 1'b0;
        end else begin
            uf = 1'b0;
            if (in_valid && r_exp) mq.push_back({in_data[2], in_data[1], in_data[0]});
            if (ld) begin
                if (mq.size() > 0) wset = mq.pop_front();
                else begin
                    wset = {IDLE_W, IDLE_W, IDLE_W};
                    uf = 1'b1;
                end
                for (int k = 0; k < 5; k++) begin
                    exp_has[cyc + 2 + k]  = 1'b1;
                    exp_k[cyc + 2 + k]    = k;
                    exp_w[cyc + 2 + k][0] = wset[9:0];
                    exp_w[cyc + 2 + k][1] = wset[19:10];
                    exp_w[cyc + 2 + k][2] = wset[29:20];
                end
                next_load = cyc + 5;
            end
            if (uf) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
            m_run = 1'b1;
        end
        cyc++;
    end

    task automatic drive_feed();
        in_valid = (feed_idx < feed_lim);
        for (int i = 0; i < 3; i++) in_data[i] = w_tab[feed_idx < 64 ? feed_idx : 63][i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_feed();
    endtask

    initial begin
        for (int i = 0; i < HN + 8; i++) exp_has[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w_tab[i][0] = 10'(i * 37 + 5);
            w_tab[i][1] = 10'(i * 11);
            w_tab[i][2] = 10'(1023 - i * 3);
        end
        w_tab[0][0] = 10'h3A5; w_tab[0][1] = 10'h200; w_tab[0][2] = 10'h0F0;
        w_tab[1][0] = 10'h15A; w_tab[1][1] = 10'h001; w_tab[1][2] = 10'h155;
        for (int i = 0; i < 3; i++) in_data[i] = 10'h000;

        // reset, then a few disabled cycles
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // two words, then starve the gearbox
        enable = 1'b1;
        feed_lim = 2;
        drive_feed();
        e_cyc = cyc;
        while (cyc < e_cyc + 15) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        while (cyc < e_cyc + 22) step();
        enable = 1'b0;
        repeat (3) step();

        // continuous supply with backpressure
        enable = 1'b1;
        feed_lim = 60;
        drive_feed();
        b_cyc = cyc;
        while (cyc < b_cyc + 109) step();

        // reset while slice 2 of a word is on the outputs
        reset = 1'b1;
        x_cyc = cyc;
        step();
        reset = 1'b0;
        repeat (12) step();

        // hand-computed pins
        chk("rst_out_a0", -1, 0, 10'(h_a0[1]), 10'(2'b00));
        chk("rst_out_c0", -1, 0, 10'(h_c0[1]), 10'(2'b11));
        chk("rst_clk_c", -1, -1, 10'(h_ckc[1]), 10'(2'b11));
        chk("rst_ready", -1, -1, 10'(h_rdy[1]), 10'(1'b0));
        for (int k = 0; k < 10; k++) chk("pin_a0", 0, 0, 10'(h_a0[e_cyc + 2 + k]), 10'(pin_a0[k]));
        for (int k = 0; k < 5; k++) begin
            chk("pin_msb_first", 1, 1, 10'(h_b1[e_cyc + 2 + k]), 10'(pin_b1[k]));
            chk("pin_clk_a", 0, -1, 10'(h_cka[e_cyc + 2 + k]), 10'(pin_cka[k]));
            chk("pin_clk_inv", 2, -1, 10'(h_ckc[e_cyc + 2 + k]), 10'(pin_ckc[k]));
            chk("pin_idle_inv", 2, 0, 10'(h_c0[e_cyc + 12 + k]), 10'(pin_c0[k]));
            chk("pin_idle_plain", 2, 1, 10'(h_c1[e_cyc + 12 + k]), 10'(pin_c1[k]));
        end
        chk("pin_ws0", 0, -1, 10'(h_ws[e_cyc + 2]), 10'(1'b1));
        chk("pin_ws1", 0, -1, 10'(h_ws[e_cyc + 3]), 10'(1'b0));
        chk("pin_ws5", 0, -1, 10'(h_ws[e_cyc + 7]), 10'(1'b1));
        chk("pin_uf_before", 0, -1, 10'(h_uf[e_cyc + 10]), 10'(1'b0));
        chk("pin_uf_rise", 0, -1, 10'(h_uf[e_cyc + 11]), 10'(1'b1));
        chk("pin_uf_set_wins", 0, -1, 10'(h_uf[e_cyc + 16]), 10'(1'b1));
        chk("pin_uf_cleared", 0, -1, 10'(h_uf[e_cyc + 18]), 10'(1'b0));
        chk("pin_accepts", 0, -1, 10'(n_acc), 10'd20);
        chk("pin_rdy_load", 0, -1, 10'(h_rdy[b_cyc + 5]), 10'(1'b1));
        for (int k = 6; k <= 9; k++) chk("pin_rdy_stall", 0, -1, 10'(h_rdy[b_cyc + k]), 10'(1'b0));
        chk("pin_rdy_next_load", 0, -1, 10'(h_rdy[b_cyc + 10]), 10'(1'b1));
        chk("pin_rst_rdy", 0, -1, 10'(h_rdy[x_cyc]), 10'(1'b0));
        chk("pin_rst_out_a0", 0, 0, 10'(h_a0[x_cyc + 1]), 10'(2'b00));
        chk("pin_rst_out_c0", 2, 0, 10'(h_c0[x_cyc + 1]), 10'(2'b11));
        chk("pin_rst_ws", 0, -1, 10'(h_ws[x_cyc + 2]), 10'(1'b0));
        chk("pin_rst_first_ws", 0, -1, 10'(h_ws[x_cyc + 3]), 10'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
